// File: rtl/servo_pkg.sv
// ============================================================================
// Module      : servo_pkg
// Description : Shared types, channel count and width helpers for the servo
//               PWM core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servo_pkg;

    typedef logic [15:0] servo_us_t;

    localparam int NUM_SERVO = 2;

    function automatic servo_us_t clamp_us(input servo_us_t v,
                                           input servo_us_t lo,
                                           input servo_us_t hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Moves cur toward tgt by at most step, never past tgt.
    function automatic servo_us_t slew_step(input servo_us_t cur,
                                            input servo_us_t tgt,
                                            input servo_us_t step);
        if (tgt > cur)
            return ((tgt - cur) > step) ? servo_us_t'(cur + step) : tgt;
        else
            return ((cur - tgt) > step) ? servo_us_t'(cur - step) : tgt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/servo_pwm_channel.sv
// ============================================================================
// Module      : servo_pwm_channel
// Description : One servo channel: target clamp, optional slew (SERVO_SLEW_EN),
//               frame-boundary shadows, sticky clamp flag and registered PWM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int MIN_US  = 500,
    parameter int MAX_US  = 2500,
    parameter int MID_US  = 1500,
    parameter int SLEW_US = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_boundary,
    input  logic [15:0] i_us_next,
    input  logic        i_en,
    input  logic [15:0] i_pw,
    input  logic        i_clamp_clr,
    output logic        o_pwm,
    output logic [15:0] o_width,
    output logic        o_clamp
);

    localparam servo_us_t c_min = servo_us_t'(MIN_US);
    localparam servo_us_t c_max = servo_us_t'(MAX_US);
    localparam servo_us_t c_mid = servo_us_t'(MID_US);

    logic      r_en_sh;
    servo_us_t r_width_sh;
    logic      r_clamp;
    logic      r_pwm;

    servo_us_t w_tgt;
    servo_us_t w_next_width;
    logic      w_out_of_range;
    logic      w_en_nx;
    servo_us_t w_width_nx;

    assign w_tgt          = clamp_us(i_pw, c_min, c_max);
    assign w_out_of_range = (i_pw < c_min) || (i_pw > c_max);

`ifdef SERVO_SLEW_EN
    assign w_next_width = slew_step(r_width_sh, w_tgt, servo_us_t'(SLEW_US));
`else
    assign w_next_width = w_tgt;
`endif

    // Compare against next-cycle state so the registered output lines up
    // with the frame-start pulse rather than lagging it by one cycle.
    assign w_en_nx    = i_boundary ? i_en : r_en_sh;
    assign w_width_nx = i_boundary ? w_next_width : r_width_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_sh    <= 1'b0;
            r_width_sh <= c_mid;
            r_clamp    <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            if (i_boundary) begin
                r_en_sh    <= i_en;
                r_width_sh <= w_next_width;
            end
            if (i_boundary && w_out_of_range)
                r_clamp <= 1'b1;
            else if (i_clamp_clr)
                r_clamp <= 1'b0;
            r_pwm <= w_en_nx && (i_us_next < w_width_nx);
        end
    end

    assign o_pwm   = r_pwm;
    assign o_width = r_width_sh;
    assign o_clamp = r_clamp;

endmodule

`default_nettype wire

// File: rtl/servo_pwm_core.sv
// ============================================================================
// Module      : servo_pwm_core
// Description : Dual-channel servo PWM generator; prescaler, microsecond frame
//               counter and boundary strobe. Optional slew via SERVO_SLEW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_core
    import servo_pkg::*;
#(
    parameter int CLK_DIV  = 100,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int MID_US   = 1500,
    parameter int SLEW_US  = 20
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [1:0]  en_i,
    input  logic [15:0] pw0_i,
    input  logic [15:0] pw1_i,
    input  logic        clamp_clr_i,
    output logic [1:0]  pwm_o,
    output logic        frame_start_o,
    output logic [15:0] width0_o,
    output logic [15:0] width1_o,
    output logic [1:0]  clamp_o
);

    localparam int                PRE_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]  c_pre_last = PRE_W'(CLK_DIV - 1);
    localparam servo_us_t         c_us_last  = servo_us_t'(FRAME_US - 1);

    logic [PRE_W-1:0] r_pre;
    servo_us_t        r_us_cnt;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_boundary;
    servo_us_t        w_us_next;
    servo_us_t        w_pw    [NUM_SERVO];
    servo_us_t        w_width [NUM_SERVO];

    assign w_tick     = (r_pre == c_pre_last);
    assign w_boundary = w_tick && (r_us_cnt == c_us_last);

    always_comb begin
        w_us_next = r_us_cnt;
        if (w_tick)
            w_us_next = (r_us_cnt == c_us_last) ? '0 : servo_us_t'(r_us_cnt + 16'd1);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pre         <= '0;
            r_us_cnt      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pre         <= w_tick ? '0 : PRE_W'(r_pre + 1'b1);
            r_us_cnt      <= w_us_next;
            r_frame_start <= w_boundary;
        end
    end

    assign w_pw[0] = pw0_i;
    assign w_pw[1] = pw1_i;

    for (genvar i = 0; i < NUM_SERVO; i++) begin : g_ch
        servo_pwm_channel #(
            .MIN_US  (MIN_US),
            .MAX_US  (MAX_US),
            .MID_US  (MID_US),
            .SLEW_US (SLEW_US)
        ) u_ch (
            .clk         (ACLK),
            .rst         (ARESET),
            .i_boundary  (w_boundary),
            .i_us_next   (w_us_next),
            .i_en        (en_i[i]),
            .i_pw        (w_pw[i]),
            .i_clamp_clr (clamp_clr_i),
            .o_pwm       (pwm_o[i]),
            .o_width     (w_width[i]),
            .o_clamp     (clamp_o[i])
        );
    end

    assign frame_start_o = r_frame_start;
    assign width0_o      = w_width[0];
    assign width1_o      = w_width[1];

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_core.sv
// ============================================================================
// Module      : tb_servo_pwm_core
// Description : Self-checking bench for servo_pwm_core (CLK_DIV=4, 100 us
//               frame); slew expectations follow SERVO_SLEW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_pwm_core;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [1:0]  en_i = 2'b11;
    logic [15:0] pw0_i = 16'd50;
    logic [15:0] pw1_i = 16'd50;
    logic        clamp_clr_i = 1'b0;
    logic [1:0]  pwm_o;
    logic        frame_start_o;
    logic [15:0] width0_o;
    logic [15:0] width1_o;
    logic [1:0]  clamp_o;

    int n_vec = 0;
    int n_bad = 0;

    servo_pwm_core #(
        .CLK_DIV  (4),
        .FRAME_US (100),
        .MIN_US   (10),
        .MAX_US   (90),
        .MID_US   (50),
        .SLEW_US  (5)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .en_i          (en_i),
        .pw0_i         (pw0_i),
        .pw1_i         (pw1_i),
        .clamp_clr_i   (clamp_clr_i),
        .pwm_o         (pwm_o),
        .frame_start_o (frame_start_o),
        .width0_o      (width0_o),
        .width1_o      (width1_o),
        .clamp_o       (clamp_o)
    );

    always #5 ACLK = ~ACLK;

    // Inputs are applied mid-frame; expectations describe the frame measured
    // while those inputs were applied.
    typedef struct {
        logic [1:0]  en;
        logic [15:0] pw0;
        logic [15:0] pw1;
        logic        clr;
        int          hi0;
        int          hi1;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [1:0]  cl;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_and_check();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_fs", int'(frame_start_o), 0);
        chk("rst_w0", int'(width0_o), 50);
        chk("rst_w1", int'(width1_o), 50);
        chk("rst_clamp", int'(clamp_o), 0);
        ARESET = 1'b0;
        begin
            int bad = 0;
            for (int k = 1; k < 400; k++) begin
                @(negedge ACLK);
                if (pwm_o != 2'b00 || frame_start_o) bad++;
            end
            chk("quiet_first_frame", bad, 0);
        end
        @(negedge ACLK);
        chk("first_frame_start", int'(frame_start_o), 1);
        chk("first_rise", int'(pwm_o), 3);
    endtask

    // Entered on a frame-start cycle; returns on the next frame-start cycle.
    task automatic measure_frame(input vec_t v, output int hi0, output int hi1,
                                 output int fs, output int fs0, output int p0,
                                 output int w0, output int w1, output int cl);
        hi0 = 0; hi1 = 0; fs = 0; fs0 = 0; p0 = 0; w0 = 0; w1 = 0; cl = 0;
        for (int j = 0; j < 400; j++) begin
            if (pwm_o[0]) hi0++;
            if (pwm_o[1]) hi1++;
            if (frame_start_o) fs++;
            if (j == 0) begin
                fs0 = int'(frame_start_o);
                p0  = int'(pwm_o);
                w0  = int'(width0_o);
                w1  = int'(width1_o);
                cl  = int'(clamp_o);
            end
            if (j == 100) begin
                en_i = v.en; pw0_i = v.pw0; pw1_i = v.pw1; clamp_clr_i = v.clr;
            end
            if (j == 101) clamp_clr_i = 1'b0;
            @(negedge ACLK);
        end
    endtask

    initial begin
        int hi0, hi1, fs, fs0, p0, w0, w1, cl;
        int exp_slew [5];

        tbl[0] = '{2'b11, 16'd30,  16'd50,  1'b0, 200, 200, 16'd50, 16'd50, 2'b00};
        tbl[1] = '{2'b11, 16'd30,  16'd5,   1'b0, 120, 200, 16'd30, 16'd50, 2'b00};
        tbl[2] = '{2'b11, 16'd30,  16'd200, 1'b0, 120, 40,  16'd30, 16'd10, 2'b10};
        tbl[3] = '{2'b11, 16'd30,  16'd60,  1'b1, 120, 360, 16'd30, 16'd90, 2'b10};
        tbl[4] = '{2'b10, 16'd30,  16'd60,  1'b0, 120, 240, 16'd30, 16'd60, 2'b00};
        tbl[5] = '{2'b11, 16'd100, 16'd60,  1'b0, 0,   240, 16'd30, 16'd60, 2'b00};
        tbl[6] = '{2'b11, 16'd100, 16'd60,  1'b0, 360, 240, 16'd90, 16'd60, 2'b01};
        tbl[7] = '{2'b11, 16'd90,  16'd60,  1'b1, 360, 240, 16'd90, 16'd60, 2'b01};
        tbl[8] = '{2'b11, 16'd0,   16'd60,  1'b0, 360, 240, 16'd90, 16'd60, 2'b00};
        tbl[9] = '{2'b11, 16'd0,   16'd60,  1'b0, 40,  240, 16'd10, 16'd60, 2'b01};

`ifdef SERVO_SLEW_EN
        exp_slew = '{55, 60, 65, 70, 70};
`else
        exp_slew = '{70, 70, 70, 70, 70};
`endif

        reset_and_check();

`ifndef SERVO_SLEW_EN
        for (int i = 0; i < 10; i++) begin
            measure_frame(tbl[i], hi0, hi1, fs, fs0, p0, w0, w1, cl);
            chk($sformatf("v%0d_hi0", i), hi0, tbl[i].hi0);
            chk($sformatf("v%0d_hi1", i), hi1, tbl[i].hi1);
            chk($sformatf("v%0d_fs_count", i), fs, 1);
            chk($sformatf("v%0d_fs_first", i), fs0, 1);
            chk($sformatf("v%0d_rise", i), p0,
                int'({tbl[i].hi1 != 0, tbl[i].hi0 != 0}));
            chk($sformatf("v%0d_w0", i), w0, int'(tbl[i].w0));
            chk($sformatf("v%0d_w1", i), w1, int'(tbl[i].w1));
            chk($sformatf("v%0d_clamp", i), cl, int'(tbl[i].cl));
        end

        // Clear on a boundary with an out-of-range request: set wins.
        repeat (399) @(negedge ACLK);
        clamp_clr_i = 1'b1;
        @(negedge ACLK);
        clamp_clr_i = 1'b0;
        chk("clr_vs_set_boundary", int'(clamp_o), 1);

        // Clear on a boundary with an in-range request: clear takes effect.
        pw0_i = 16'd50;
        repeat (399) @(negedge ACLK);
        clamp_clr_i = 1'b1;
        @(negedge ACLK);
        clamp_clr_i = 1'b0;
        chk("clr_in_range_boundary", int'(clamp_o), 0);
        chk("w0_back_to_50", int'(width0_o), 50);
`endif

        // Reset mid-pulse.
        en_i = 2'b11; pw0_i = 16'd70; pw1_i = 16'd30;
        repeat (400) @(negedge ACLK);
        repeat (60) @(negedge ACLK);
        chk("pre_reset_high", int'(pwm_o), 3);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("reset_pwm_low", int'(pwm_o), 0);
        chk("reset_w0_mid", int'(width0_o), 50);
        chk("reset_w1_mid", int'(width1_o), 50);
        pw0_i = 16'd50; pw1_i = 16'd50;
        reset_and_check();

        // Width step 50 -> 70, ramped or immediate depending on build.
        repeat (100) @(negedge ACLK);
        pw0_i = 16'd70;
        repeat (300) @(negedge ACLK);
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("ramp%0d_fs", f), int'(frame_start_o), 1);
            chk($sformatf("ramp%0d_w0", f), int'(width0_o), exp_slew[f]);
            repeat (400) @(negedge ACLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/servo_pwm_core.md
# servo_pwm_core

Dual-channel hobby-servo PWM generator for the ball-and-plate platform, directly downstream of the servo AXI4-Lite register file. Consumes the register file's enable and pulse-width fields and drives the two plate-tilt servo pins. Widths and enables are applied only at frame boundaries, so a pulse is never truncated or glitched. Applied widths are reported back for register readback.

## Interface
- CLK_DIV, 100: ACLK cycles per 1 µs tick (100 MHz ACLK).
- FRAME_US, 20000: frame period in µs (50 Hz).
- MIN_US, 500: lower clamp on pulse width.
- MAX_US, 2500: upper clamp on pulse width; must be < FRAME_US.
- MID_US, 1500: reset/neutral width.
- SLEW_US, 20: max width change per frame (slew build only).

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  synchronous, active-high reset.
- en_i  in  2  per-channel enable from the control register.
- pw0_i  in  16  requested width for channel 0, in µs.
- pw1_i  in  16  requested width for channel 1, in µs.
- clamp_clr_i  in  1  clears clamp_o.
- pwm_o  out  2  servo PWM outputs, registered.
- frame_start_o  out  1  one-cycle pulse at each frame start.
- width0_o  out  16  currently applied width, channel 0.
- width1_o  out  16  currently applied width, channel 1.
- clamp_o  out  2  sticky flag: request was clamped at some boundary.

## Operation
- Prescaler `pre` counts 0..CLK_DIV-1. `tick` is asserted when pre == CLK_DIV-1.
- µs counter `us_cnt` counts 0..FRAME_US-1, advances on tick, and wraps to 0.
- Boundary: tick && us_cnt == FRAME_US-1. On that cycle these shadows load, effective from us_cnt = 0:
  - en_sh ← en_i.
  - width_sh[i] ← next_width[i].
- Target: tgt[i] = clamp(pw_i, MIN_US, MAX_US). Comparison is unsigned 16-bit.
  - At a boundary, if pw_i < MIN_US or pw_i > MAX_US, clamp_o[i] sets.
  - Set has priority over a simultaneous clamp_clr_i.
- Without slew: next_width = tgt.
- pwm_o[i] ← en_sh[i] && (us_cnt < width_sh[i]), registered each cycle.
- width{0,1}_o = width_sh. The values change only at a boundary.
- Inputs may change at any time. Only their value on the boundary cycle matters.

## Timing
- Reset values:
  - pre = 0, us_cnt = 0.
  - en_sh = 0, width_sh = MID_US.
  - pwm_o = 0, frame_start_o = 0, clamp_o = 0.
- First boundary is FRAME_US*CLK_DIV cycles after reset release. Channels stay low until then, because en_sh = 0.
- frame_start_o and the pwm_o rising edge occur on the same cycle: the cycle after the boundary.
- High time is exactly width_sh*CLK_DIV cycles. Period is exactly FRAME_US*CLK_DIV cycles.
- Enable or width change latency: applied at the next boundary. The in-flight frame is never altered.
- Disable at a boundary: the next frame has no pulse. The current pulse always completes.
- ARESET mid-pulse: pwm_o goes low the cycle after ARESET is sampled, and all state returns to reset values.

## Configuration
- SERVO_SLEW_EN defined:
  - next_width = width_sh + min(tgt − width_sh, SLEW_US) when stepping up.
  - next_width = width_sh − min(width_sh − tgt, SLEW_US) when stepping down.
  - Large requests ramp one step per frame, and never overshoot tgt.
- SERVO_SLEW_EN undefined: next_width = tgt, and SLEW_US is unused.

## Structure
- Package servo_pkg holds:
  - `typedef logic [15:0] servo_us_t`
  - NUM_SERVO = 2
  - the clamp function
  - the slew-step function
- Sub-module servo_pwm_channel, instantiated once per channel. It contains:
  - the target clamp and slew logic
  - width_sh and en_sh
  - the clamp flag
  - the registered pwm compare
- The top level holds the prescaler, the µs counter and the boundary strobe.

## Test plan
Bench parameters: CLK_DIV=4, FRAME_US=100, MIN=10, MAX=90, MID=50, SLEW=5.
- Reset, en_i=2'b11, pw=50:
  - no pulse for the first 400 cycles
  - then pulses of 200 cycles high in a 400-cycle period
  - frame_start_o aligned with each rising edge
- pw0 changed 50→30 mid-pulse: the current pulse stays 200 cycles, the next is 120 cycles, and width0_o updates at the boundary.
- pw1=5, then pw1=200:
  - widths 10 and 90 applied
  - clamp_o[1] set
  - clamp_clr_i clears it only when that cycle is not a boundary with an out-of-range request
- en_i[0] dropped mid-pulse: the pulse completes, the following frame is low, and channel 1 is unaffected.
- SERVO_SLEW_EN, pw0 50→70: successive widths 55, 60, 65, 70, 70. Without the macro: 70 immediately.
- ARESET asserted mid-pulse: pwm_o low the next cycle, width_sh=50, and normal timing resumes after release.
